// File: rtl/ccsds_123b2_output_stream_checker.sv
// Self-test sink for the 64-bit compressed bitstream: counts and sums accepted words,
// then judges the stream against reference count/checksum at TLAST, overrun or timeout.
module ccsds_123b2_output_stream_checker #(
    parameter int          REF_CNT_LIMIT = 4881,
    parameter logic [63:0] REF_CHECKSUM  = 64'h0004360006B58000,
    parameter int          TIMEOUT_LIMIT = 217500,
    parameter bit          BACKPRESSURE  = 1'b0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        selfcheck_init,
    input  logic [63:0] axis_in_d,
    input  logic        axis_in_valid,
    input  logic        axis_in_last,
    output logic        axis_in_ready,
    output logic        selfcheck_working,
    output logic        selfcheck_finished,
    output logic        selfcheck_failed,
    output logic        selfcheck_timeout,
    output logic [31:0] word_count,
    output logic [63:0] checksum
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        DONE_OK   = 3'd2,
        DONE_FAIL = 3'd3,
        TIMEOUT   = 3'd4
    } state_t;

    localparam logic [31:0] CNT_LIMIT  = 32'(REF_CNT_LIMIT);
    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_LIMIT - 1);
    localparam logic [31:0] TIMER_MAX  = 32'hFFFF_FFFF;

    state_t      state_reg, state_next;
    logic [31:0] count_reg, count_next;
    logic [63:0] sum_reg, sum_next;
    logic [31:0] timer_reg, timer_next;
    logic [15:0] lfsr_reg, lfsr_next;
    logic [15:0] lfsr_step;

    logic        running;
    logic        ready_int;
    logic        handshake;
    logic [31:0] count_inc;
    logic [63:0] sum_inc;
    logic        count_hit;
    logic        terminate;
    logic        stream_ok;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1 (taps at bits 0,2,3,5)
    assign lfsr_step[15] = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];
    generate
        for (genvar gi = 0; gi < 15; gi++) begin : g_lfsr_shift
            assign lfsr_step[gi] = lfsr_reg[gi + 1];
        end
    endgenerate

    assign running   = (state_reg == RUN);
    assign ready_int = running & (BACKPRESSURE ? lfsr_reg[0] : 1'b1);
    assign handshake = axis_in_valid & ready_int;
    assign count_inc = count_reg + 32'd1;
    assign sum_inc   = sum_reg + axis_in_d;
    assign count_hit = (count_inc == CNT_LIMIT);
    // Reaching the limit without TLAST also ends the run so no extra words are swallowed
    assign terminate = handshake & (axis_in_last | count_hit);
    assign stream_ok = axis_in_last & count_hit & (sum_inc == REF_CHECKSUM);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        sum_next   = sum_reg;
        timer_next = timer_reg;
        lfsr_next  = lfsr_reg;
        if (selfcheck_init) begin
            state_next = RUN;
            count_next = '0;
            sum_next   = '0;
            timer_next = '0;
            lfsr_next  = LFSR_SEED;
        end else if (running) begin
            lfsr_next  = lfsr_step;
            timer_next = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + 32'd1;
            if (handshake) begin
                count_next = count_inc;
                sum_next   = sum_inc;
            end
            if (terminate) begin
                state_next = stream_ok ? DONE_OK : DONE_FAIL;
            end else if (timer_reg == TIMER_LAST) begin
                state_next = TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            sum_reg   <= '0;
            timer_reg <= '0;
            lfsr_reg  <= LFSR_SEED;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            sum_reg   <= sum_next;
            timer_reg <= timer_next;
            lfsr_reg  <= lfsr_next;
        end
    end

    assign axis_in_ready      = ready_int;
    assign selfcheck_working  = running;
    assign selfcheck_finished = (state_reg == DONE_OK) | (state_reg == DONE_FAIL);
    assign selfcheck_failed   = (state_reg == DONE_FAIL);
    assign selfcheck_timeout  = (state_reg == TIMEOUT);
    assign word_count         = count_reg;
    assign checksum           = sum_reg;

endmodule

// File: tb/tb_ccsds_123b2_output_stream_checker.sv
// Bench for the output stream checker: two instances (steady ready / LFSR backpressure)
// with shortened reference length and timeout, table vectors, random streams and corner sequences.
module tb_ccsds_123b2_output_stream_checker;

    localparam int          L    = 40;
    localparam int          TL   = 600;
    localparam logic [15:0] SEED = 16'hACE1;

    // Reference words are all even, so flipping bit 0 of one word adds exactly 1 to the sum
    function automatic logic [63:0] ref_word(input int k);
        return (64'(k) * 64'h9E3779B97F4A7C15 + 64'h0123456789ABCDE0) & ~64'h1;
    endfunction

    function automatic logic [63:0] ref_sum_calc();
        logic [63:0] s;
        s = '0;
        for (int k = 1; k <= L; k++) s = s + ref_word(k);
        return s;
    endfunction

    localparam logic [63:0] REF_SUM = ref_sum_calc();

    logic        clk;
    logic        rst;
    logic        init0, init1;
    logic [63:0] d;
    logic        valid, last;
    logic        ready0, working0, fin0, failed0, tmo0;
    logic        ready1, working1, fin1, failed1, tmo1;
    logic [31:0] cnt0, cnt1;
    logic [63:0] sum0, sum1;

    int checks = 0;
    int errors = 0;
    int sel = 0;

    ccsds_123b2_output_stream_checker #(
        .REF_CNT_LIMIT(L), .REF_CHECKSUM(REF_SUM), .TIMEOUT_LIMIT(TL),
        .BACKPRESSURE(1'b0), .LFSR_SEED(SEED)
    ) dut0 (
        .clk(clk), .rst(rst), .selfcheck_init(init0),
        .axis_in_d(d), .axis_in_valid(valid), .axis_in_last(last), .axis_in_ready(ready0),
        .selfcheck_working(working0), .selfcheck_finished(fin0), .selfcheck_failed(failed0),
        .selfcheck_timeout(tmo0), .word_count(cnt0), .checksum(sum0)
    );

    ccsds_123b2_output_stream_checker #(
        .REF_CNT_LIMIT(L), .REF_CHECKSUM(REF_SUM), .TIMEOUT_LIMIT(TL),
        .BACKPRESSURE(1'b1), .LFSR_SEED(SEED)
    ) dut1 (
        .clk(clk), .rst(rst), .selfcheck_init(init1),
        .axis_in_d(d), .axis_in_valid(valid), .axis_in_last(last), .axis_in_ready(ready1),
        .selfcheck_working(working1), .selfcheck_finished(fin1), .selfcheck_failed(failed1),
        .selfcheck_timeout(tmo1), .word_count(cnt1), .checksum(sum1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          bp_sel;
        int          last_pos;
        int          flip_word;
        int          flip_bit;
        int          exp_fin;
        int          exp_fail;
        int          exp_cnt;
        logic [63:0] exp_sum;
    } vec_t;

    vec_t tv[7];

    // 0 ready, 1 working, 2 finished, 3 failed, 4 timeout, 5 count, 6 checksum
    function automatic logic [63:0] probe(input int what);
        logic [63:0] v;
        v = '0;
        case (what)
            0: v = 64'(sel == 1 ? ready1 : ready0);
            1: v = 64'(sel == 1 ? working1 : working0);
            2: v = 64'(sel == 1 ? fin1 : fin0);
            3: v = 64'(sel == 1 ? failed1 : failed0);
            4: v = 64'(sel == 1 ? tmo1 : tmo0);
            5: v = 64'(sel == 1 ? cnt1 : cnt0);
            default: v = (sel == 1) ? sum1 : sum0;
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (dut%0d): got %0h, expected %0h", name, sel, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_init();
        if (sel == 1) init1 = 1'b1;
        else init0 = 1'b1;
        tick();
        init0 = 1'b0;
        init1 = 1'b0;
    endtask

    function automatic logic [63:0] stream_word(input int k, input int fw, input int fb);
        logic [63:0] m;
        m = (k == fw) ? (64'h1 << fb) : 64'h0;
        return ref_word(k) ^ m;
    endfunction

    // Spec-level judgement of a stream: words accumulate until TLAST or until the limit is hit
    task automatic model_run(input int last_pos, input int fw, input int fb,
                             output int n, output logic [63:0] s, output bit ok);
        s = '0;
        n = 0;
        ok = 1'b0;
        for (int k = 1; k <= L; k++) begin
            n = k;
            s = s + stream_word(k, fw, fb);
            if (k == last_pos) begin
                ok = (n == L) && (s == REF_SUM);
                break;
            end
        end
    endtask

    task automatic send_words(input int n, input int last_pos, input int fw, input int fb,
                              input int gap_pct);
        int waited;
        for (int k = 1; k <= n; k++) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                valid = 1'b0;
                last  = 1'b0;
                tick();
            end
            d     = stream_word(k, fw, fb);
            valid = 1'b1;
            last  = (k == last_pos);
            waited = 0;
            while (probe(0) !== 64'h1) begin
                tick();
                waited++;
                if (waited > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL handshake word %0d (dut%0d): ready=%0h after %0d cycles, expected 1",
                             k, sel, probe(0), waited);
                    valid = 1'b0;
                    last  = 1'b0;
                    return;
                end
            end
            tick();
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic check_done(input int ef, input int efl, input int ec, input logic [63:0] es);
        chk("working", probe(1), 64'h0);
        chk("finished", probe(2), 64'(ef));
        chk("failed", probe(3), 64'(efl));
        chk("timeout", probe(4), 64'h0);
        chk("ready", probe(0), 64'h0);
        chk("word_count", probe(5), 64'(ec));
        chk("checksum", probe(6), es);
    endtask

    initial begin
        int          n;
        logic [63:0] s;
        bit          ok;
        int          lp, fw, fb;
        logic [15:0] lf;
        logic        fbit;

        tv[0] = '{0, L,     0,  0,  1, 0, L,     REF_SUM};
        tv[1] = '{0, L,     10, 0,  1, 1, L,     REF_SUM ^ 64'h1};
        tv[2] = '{0, L - 1, 0,  0,  1, 1, L - 1, REF_SUM - ref_word(L)};
        tv[3] = '{0, 0,     0,  0,  1, 1, L,     REF_SUM};
        tv[4] = '{1, L,     0,  0,  1, 0, L,     REF_SUM};
        tv[5] = '{1, L,     L,  63, 1, 1, L,     REF_SUM ^ 64'h8000_0000_0000_0000};
        tv[6] = '{1, 1,     0,  0,  1, 1, 1,     ref_word(1)};

        rst = 1'b1; init0 = 1'b0; init1 = 1'b0;
        valid = 1'b0; last = 1'b0; d = '0;
        repeat (3) tick();
        for (int si = 0; si < 2; si++) begin
            sel = si;
            for (int w = 0; w < 7; w++) chk("reset_out", probe(w), 64'h0);
            $display("reset state dut%0d checked", si);
        end
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            sel = tv[i].bp_sel;
            do_init();
            model_run(tv[i].last_pos, tv[i].flip_word, tv[i].flip_bit, n, s, ok);
            send_words(n, tv[i].last_pos, tv[i].flip_word, tv[i].flip_bit, 20);
            check_done(tv[i].exp_fin, tv[i].exp_fail, tv[i].exp_cnt, tv[i].exp_sum);
            $display("vector %0d dut%0d: words=%0d count=%0d sum=%h failed=%0h",
                     i, sel, n, probe(5), probe(6), probe(3));
        end

        for (int r = 0; r < 12; r++) begin
            sel = int'($urandom_range(1));
            case ($urandom_range(9))
                0, 1, 2, 3, 4, 5: lp = L;
                6, 7:             lp = int'($urandom_range(L - 1, 1));
                default:          lp = 0;
            endcase
            if ($urandom_range(1) == 1) begin
                fw = int'($urandom_range(L, 1));
                fb = int'($urandom_range(63));
            end else begin
                fw = 0;
                fb = 0;
            end
            do_init();
            model_run(lp, fw, fb, n, s, ok);
            send_words(n, lp, fw, fb, 20);
            check_done(1, ok ? 0 : 1, n, s);
            $display("random %0d dut%0d: last=%0d flip=%0d/%0d words=%0d expect_ok=%0d",
                     r, sel, lp, fw, fb, n, ok);
        end

        sel = 0;
        do_init();
        send_words(L, 0, 0, 0, 0);
        check_done(1, 1, L, REF_SUM);
        d = ref_word(1);
        valid = 1'b1;
        last = 1'b1;
        repeat (4) tick();
        chk("overrun_ready", probe(0), 64'h0);
        chk("overrun_count", probe(5), 64'(L));
        chk("overrun_sticky", probe(3), 64'h1);
        valid = 1'b0;
        last = 1'b0;
        $display("overrun sequence: count=%0d", probe(5));

        sel = 1;
        do_init();
        lf = SEED;
        for (int c = 0; c < 32; c++) begin
            chk("lfsr_ready", probe(0), 64'(lf[0]));
            tick();
            fbit = lf[0] ^ lf[2] ^ lf[3] ^ lf[5];
            lf = {fbit, lf[15:1]};
        end
        $display("backpressure ready pattern: 32 cycles compared");

        for (int si = 0; si < 2; si++) begin
            sel = si;
            do_init();
            send_words(5, 0, 0, 0, 0);
            d = ref_word(6);
            valid = 1'b1;
            last = 1'b0;
            if (sel == 1) init1 = 1'b1;
            else init0 = 1'b1;
            tick();
            init0 = 1'b0;
            init1 = 1'b0;
            valid = 1'b0;
            chk("reinit_count", probe(5), 64'h0);
            chk("reinit_sum", probe(6), 64'h0);
            chk("reinit_working", probe(1), 64'h1);
            send_words(L, L, 0, 0, 10);
            check_done(1, 0, L, REF_SUM);
            $display("reinit mid-stream dut%0d: count=%0d", si, probe(5));
        end

        sel = 0;
        do_init();
        chk("to_working0", probe(1), 64'h1);
        repeat (TL - 1) tick();
        chk("to_early", probe(4), 64'h0);
        chk("to_early_working", probe(1), 64'h1);
        tick();
        chk("to_flag", probe(4), 64'h1);
        chk("to_working", probe(1), 64'h0);
        chk("to_finished", probe(2), 64'h0);
        chk("to_failed", probe(3), 64'h0);
        chk("to_ready", probe(0), 64'h0);
        repeat (5) tick();
        chk("to_sticky", probe(4), 64'h1);
        $display("timeout sequence: timeout=%0h", probe(4));

        do_init();
        repeat (TL - L) tick();
        send_words(L, L, 0, 0, 0);
        check_done(1, 0, L, REF_SUM);
        $display("last word on final timer cycle: finished=%0h", probe(2));

        do_init();
        send_words(20, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        for (int w = 0; w < 7; w++) chk("midrun_rst", probe(w), 64'h0);
        rst = 1'b0;
        tick();
        do_init();
        send_words(L, L, 0, 0, 20);
        check_done(1, 0, L, REF_SUM);
        $display("reset mid-run then full stream: count=%0d", probe(5));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
